paddle_timing_decoder: RTL
==========================

PADDLE_TIMING_DECODER -- requirements
Module: paddle_timing_decoder

Interface
REQ-001 SHALL have port clk_sys, input, 1: sole clock; all state on its rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-low reset; the only clock and reset are clk_sys and reset.
REQ-003 SHALL have port hs, input, 1: active-high horizontal sync, synchronous to clk_sys.
REQ-004 SHALL have port vs, input, 1: active-high vertical sync, synchronous to clk_sys.
REQ-005 SHALL have port cmp_in, input, 2: raw asynchronous paddle-capacitor comparator levels, high = charged past threshold; bit0 = P1, bit1 = P2.
REQ-006 SHALL have port invert, input, 2: per-channel position inversion, quasi-static.
REQ-007 SHALL have port discharge, output, 2: active-high capacitor discharge drive, per channel.
REQ-008 SHALL have port pos0, output, 8: last published P1 position.
REQ-009 SHALL have port pos1, output, 8: last published P2 position.
REQ-010 SHALL have port pos_valid, output, 1: one-cycle strobe; pos0/pos1/timeout updated.
REQ-011 SHALL have port timeout, output, 2: per channel, set when the last published frame saw no charge.

Function
REQ-012 SHALL pass each cmp_in bit through a 2-flop synchronizer, then a filter that changes state only after 4 consecutive equal synchronized samples.
REQ-013 SHALL detect vs_rise/hs_rise as 0->1 transitions against the previous-cycle value.
REQ-014 SHALL implement per channel states WAIT (after reset), COUNT, DONE.
REQ-015 WAIT: on vs_rise -> COUNT, line counter = 0, no publish.
REQ-016 COUNT: each hs_rise increments the 8-bit line counter; saturates at 255, no wrap.
REQ-017 COUNT: first cycle filtered cmp is high -> latch the counter value present in that cycle (pre-increment if hs_rise coincides), timeout_pending = 0, -> DONE.
REQ-018 COUNT: counter at 255 and filtered cmp low at vs_rise -> latch 255, timeout_pending = 1.
REQ-019 DONE: ignores hs and cmp until vs_rise.
REQ-020 From COUNT or DONE, vs_rise SHALL publish: posN = latched ^ {8{invert[N]}}, timeout[N] = timeout_pending; then counter = 0, state COUNT.
REQ-021 Both channels SHALL publish on the same vs_rise; pos_valid high exactly 1 clk_sys cycle after the vs_rise cycle, outputs stable from that cycle.
REQ-022 vs_rise and hs_rise in the same cycle: vs takes priority, that hs edge is not counted.
REQ-023 Filtered cmp already high on the cycle after vs_rise: latch 0.
REQ-024 discharge[N] SHALL equal vs delayed one cycle (registered), both bits identical.
REQ-025 invert changes SHALL take effect at the next publish only.

Reset
REQ-026 reset low SHALL asynchronously force: state WAIT, counters 0, filters/synchronizers 0, pos0=pos1=8'h00, timeout=2'b00, pos_valid=0, discharge=2'b00.
REQ-027 Reset asserted mid-frame SHALL discard partial measurements; first pos_valid after release follows the second vs_rise.

Structure
REQ-028 Shared package SHALL hold LINE_MAX (255), FILT_LEN (4) and the channel state enum.
REQ-029 Per-channel logic (synchronizer, filter, FSM, counter, latch) SHALL be sub-module paddle_channel, instantiated twice; top holds edge detection, discharge and pos_valid.

Verification
REQ-030 Reset release, two vs pulses, cmp0 rising after hs edge 100, cmp1 after edge 40, invert=00 -> pos_valid 1 cycle after 2nd vs_rise, pos0=100, pos1=40, timeout=00.
REQ-031 cmp0 held low for 300 lines -> pos0=255, timeout[0]=1; next frame with cmp0 at line 10 -> pos0=10, timeout[0]=0.
REQ-032 invert=01, cmp0 at line 100 -> pos0=155 (0x9B).
REQ-033 cmp0 glitch high for 3 cycles at line 20, then stable high at line 60 -> pos0=60; glitch of 4 cycles at line 20 -> pos0=20.
REQ-034 hs_rise coincident with vs_rise, cmp0 high from line 5 -> pos0=5; cmp0 high through vs -> pos0=0.
REQ-035 reset pulsed low at line 50 of a measuring frame -> outputs zero immediately; no pos_valid on the first vs_rise after release, valid on the second.

Source files
------------

// File: rtl/paddle_timing_decoder_pkg.sv
// Shared constants and channel state encoding for the paddle timing decoder.
package paddle_timing_decoder_pkg;

    localparam logic [7:0] LINE_MAX = 8'd255;
    localparam int         FILT_LEN = 4;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } chan_state_t;

endpackage

// File: rtl/paddle_channel.sv
// One paddle channel: comparator synchronizer, glitch filter, line counter
// and per-frame capture/publish of the charge-crossing line.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_WAIT  | after reset, no frame reference yet; wait for first vs
//   ST_COUNT | counting hs lines, waiting for filtered comparator high
//   ST_DONE  | crossing line latched; ignore hs/cmp until next vs
module paddle_channel
    import paddle_timing_decoder_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       cmp_raw,
    input  logic       invert,
    input  logic       vs_rise,
    input  logic       hs_rise,
    output logic [7:0] pos,
    output logic       timeout,
    output logic       publish
);

    logic [1:0]          sync_q;
    logic [FILT_LEN-1:0] hist_q;
    logic                filt_q;
    chan_state_t         state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          lat_q, lat_d;
    logic [7:0]          pos_d;
    logic                tmo_d;

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], cmp_raw};
            hist_q <= {hist_q[FILT_LEN-2:0], sync_q[1]};
            if (&hist_q)
                filt_q <= 1'b1;
            else if (~|hist_q)
                filt_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
            lat_q   <= '0;
            pos     <= '0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            pos     <= pos_d;
            timeout <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        pos_d   = pos;
        tmo_d   = timeout;
        publish = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (vs_rise) begin
                    state_d = ST_COUNT;
                    cnt_d   = '0;
                end
            end
            ST_COUNT: begin
                // No crossing this frame: the (saturated) count is the result,
                // flagged as a timeout unless the comparator fires on this very cycle.
                if (vs_rise) begin
                    publish = 1'b1;
                    pos_d   = cnt_q ^ {8{invert}};
                    tmo_d   = ~filt_q;
                    cnt_d   = '0;
                end else if (filt_q) begin
                    lat_d   = cnt_q;
                    state_d = ST_DONE;
                end else if (hs_rise && (cnt_q != LINE_MAX)) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                if (vs_rise) begin
                    publish = 1'b1;
                    pos_d   = lat_q ^ {8{invert}};
                    tmo_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_COUNT;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

endmodule

// File: rtl/paddle_timing_decoder.sv
// Two-channel paddle position decoder: sync edge detection, capacitor
// discharge drive and the shared publish strobe around two paddle_channel instances.
module paddle_timing_decoder
    import paddle_timing_decoder_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       hs,
    input  logic       vs,
    input  logic [1:0] cmp_in,
    input  logic [1:0] invert,
    output logic [1:0] discharge,
    output logic [7:0] pos0,
    output logic [7:0] pos1,
    output logic       pos_valid,
    output logic [1:0] timeout
);

    logic       hs_q, vs_q;
    logic       hs_rise, vs_rise;
    logic [1:0] publish;

    assign hs_rise = hs & ~hs_q;
    assign vs_rise = vs & ~vs_q;

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            discharge <= 2'b00;
            pos_valid <= 1'b0;
        end else begin
            hs_q      <= hs;
            vs_q      <= vs;
            discharge <= {2{vs}};
            // Channels share vs_rise and reset, so they always publish together.
            pos_valid <= publish[0] & publish[1];
        end
    end

    paddle_channel u_ch0 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .cmp_raw (cmp_in[0]),
        .invert  (invert[0]),
        .vs_rise (vs_rise),
        .hs_rise (hs_rise),
        .pos     (pos0),
        .timeout (timeout[0]),
        .publish (publish[0])
    );

    paddle_channel u_ch1 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .cmp_raw (cmp_in[1]),
        .invert  (invert[1]),
        .vs_rise (vs_rise),
        .hs_rise (hs_rise),
        .pos     (pos1),
        .timeout (timeout[1]),
        .publish (publish[1])
    );

endmodule
